memory_system: RTL and testbench

- Unified on-chip storage for the Mamba accelerator.
- Holds two ping-pong activation banks (RAM A, RAM B), a read-only-to-core weight RAM and a read-only-to-core constant RAM.
- The global controller reads activations from one bank and writes results to the other, selected by bank_sel.
- Weight and constant data are preloaded through a DMA write port; the DMA port can also preload either activation bank.

---
 rtl/memory_system_pkg.sv | 19 +
 rtl/memory_system_if.sv | 35 +++
 rtl/sram_bank.sv | 43 ++++
 rtl/memory_system.sv | 100 ++++++++++
 tb/tb_memory_system.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/memory_system_pkg.sv
// Shared widths, DMA target encodings and controller memory-map constants
// for the accelerator storage block.
package memory_system_pkg;

  localparam int unsigned DATA_W = 256;
  localparam int unsigned ADDR_W = 15;

  typedef enum logic [1:0] {
    DMA_RAM_A  = 2'd0,
    DMA_RAM_B  = 2'd1,
    DMA_WEIGHT = 2'd2,
    DMA_CONST  = 2'd3
  } dma_target_e;

  localparam int unsigned ADDR_DEBUG_IN  = 0;
  localparam int unsigned W_BASE_OUTPROJ = 2432;
  localparam int unsigned ADDR_DEBUG_OUT = 20000;

endpackage

// File: rtl/memory_system_if.sv
// Core, weight, constant and DMA ports of the storage block. The controller
// side uses the master modport, the memory side uses the slave modport.
interface memory_system_if
  import memory_system_pkg::*;
;
  logic              bank_sel;
  logic [ADDR_W-1:0] core_read_addr;
  logic [DATA_W-1:0] core_read_data;
  logic              core_write_en;
  logic [ADDR_W-1:0] core_write_addr;
  logic [DATA_W-1:0] core_write_data;
  logic [ADDR_W-1:0] weight_read_addr;
  logic [DATA_W-1:0] weight_read_data;
  logic [ADDR_W-1:0] const_read_addr;
  logic [DATA_W-1:0] const_read_data;
  logic              dma_write_en;
  logic [1:0]        dma_target;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;

  modport master (
    output bank_sel, core_read_addr, core_write_en, core_write_addr, core_write_data,
    output weight_read_addr, const_read_addr,
    output dma_write_en, dma_target, dma_addr, dma_wdata,
    input  core_read_data, weight_read_data, const_read_data
  );

  modport slave (
    input  bank_sel, core_read_addr, core_write_en, core_write_addr, core_write_data,
    input  weight_read_addr, const_read_addr,
    input  dma_write_en, dma_target, dma_addr, dma_wdata,
    output core_read_data, weight_read_data, const_read_data
  );

endinterface

// File: rtl/sram_bank.sv
// Single-clock RAM: one write port, one registered read port with
// read-old-data semantics; out-of-range writes dropped, reads return 0.
module sram_bank #(
  parameter int unsigned DEPTH  = 32768,
  parameter int unsigned DATA_W = memory_system_pkg::DATA_W
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                we,
  input  logic [memory_system_pkg::ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]                   wdata,
  input  logic [memory_system_pkg::ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0]                   rdata
);

  localparam int unsigned AddrW = memory_system_pkg::ADDR_W;
  localparam int unsigned IdxW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AddrW:0] DepthLim = DEPTH[AddrW:0];

  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic              w_ok;
  logic              r_ok;

  assign w_ok = ({1'b0, waddr} < DepthLim);
  assign r_ok = ({1'b0, raddr} < DepthLim);

  // Reset clears only the read register; the array keeps its contents and
  // no write lands while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      if (we && w_ok) begin
        ram[waddr[IdxW-1:0]] <= wdata;
      end
      rdata_q <= r_ok ? ram[raddr[IdxW-1:0]] : '0;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/memory_system.sv
// Storage top: ping-pong activation banks plus weight and constant RAMs,
// with bank selection and DMA-over-core write priority.
module memory_system
  import memory_system_pkg::*;
#(
  parameter int unsigned DEPTH_ACT = 32768,
  parameter int unsigned DEPTH_W   = 32768,
  parameter int unsigned DEPTH_C   = 32768
) (
  input  logic        clk,
  input  logic        reset,
  memory_system_if.slave bus
);

  logic              bank_sel_q;
  logic              dma_a, dma_b, dma_w, dma_c;
  logic              core_a, core_b;
  logic              we_a, we_b;
  logic [ADDR_W-1:0] waddr_a, waddr_b;
  logic [DATA_W-1:0] wdata_a, wdata_b;
  logic [DATA_W-1:0] rdata_a, rdata_b;

  // Remembers which bank the in-flight core read came from.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_sel_q <= 1'b0;
    end else begin
      bank_sel_q <= bus.bank_sel;
    end
  end

  always_comb begin
    dma_a = 1'b0;
    dma_b = 1'b0;
    dma_w = 1'b0;
    dma_c = 1'b0;
    if (bus.dma_write_en) begin
      unique case (dma_target_e'(bus.dma_target))
        DMA_RAM_A:  dma_a = 1'b1;
        DMA_RAM_B:  dma_b = 1'b1;
        DMA_WEIGHT: dma_w = 1'b1;
        DMA_CONST:  dma_c = 1'b1;
        default:    ;
      endcase
    end
  end

  // Core always writes the bank it is not reading; DMA wins a shared bank.
  assign core_a  = bus.core_write_en &  bus.bank_sel;
  assign core_b  = bus.core_write_en & ~bus.bank_sel;
  assign we_a    = dma_a | core_a;
  assign we_b    = dma_b | core_b;
  assign waddr_a = dma_a ? bus.dma_addr  : bus.core_write_addr;
  assign wdata_a = dma_a ? bus.dma_wdata : bus.core_write_data;
  assign waddr_b = dma_b ? bus.dma_addr  : bus.core_write_addr;
  assign wdata_b = dma_b ? bus.dma_wdata : bus.core_write_data;

  sram_bank #(.DEPTH(DEPTH_ACT), .DATA_W(DATA_W)) ram_a (
    .clk   (clk),
    .rst_n (reset),
    .we    (we_a),
    .waddr (waddr_a),
    .wdata (wdata_a),
    .raddr (bus.core_read_addr),
    .rdata (rdata_a)
  );

  sram_bank #(.DEPTH(DEPTH_ACT), .DATA_W(DATA_W)) ram_b (
    .clk   (clk),
    .rst_n (reset),
    .we    (we_b),
    .waddr (waddr_b),
    .wdata (wdata_b),
    .raddr (bus.core_read_addr),
    .rdata (rdata_b)
  );

  sram_bank #(.DEPTH(DEPTH_W), .DATA_W(DATA_W)) ram_w (
    .clk   (clk),
    .rst_n (reset),
    .we    (dma_w),
    .waddr (bus.dma_addr),
    .wdata (bus.dma_wdata),
    .raddr (bus.weight_read_addr),
    .rdata (bus.weight_read_data)
  );

  sram_bank #(.DEPTH(DEPTH_C), .DATA_W(DATA_W)) ram_c (
    .clk   (clk),
    .rst_n (reset),
    .we    (dma_c),
    .waddr (bus.dma_addr),
    .wdata (bus.dma_wdata),
    .raddr (bus.const_read_addr),
    .rdata (bus.const_read_data)
  );

  assign bus.core_read_data = bank_sel_q ? rdata_b : rdata_a;

endmodule

// File: tb/tb_memory_system.sv
// Scoreboard bench for memory_system: expected read data is queued when a
// read is issued and compared one cycle later.
module tb_memory_system;
  import memory_system_pkg::*;

  localparam logic [31:0] SEED_A = 32'hA000_0001;
  localparam logic [31:0] SEED_B = 32'hB000_0002;
  localparam logic [31:0] SEED_W = 32'hC000_0003;
  localparam logic [31:0] SEED_C = 32'hD000_0004;
  localparam int unsigned PORT_CORE = 0;
  localparam int unsigned PORT_W    = 1;
  localparam int unsigned PORT_C    = 2;

  typedef struct {
    int unsigned       port;
    logic [DATA_W-1:0] exp;
  } sb_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  sb_t  sb_q[$];

  memory_system_if bus ();

  memory_system #(.DEPTH_C(16384)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic [DATA_W-1:0] pat(input logic [31:0] seed, input int unsigned a);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < 8; i++) begin
      w[i*32 +: 32] = seed ^ (32'(a) * 32'h9E37_79B1) ^ 32'(i);
    end
    return w;
  endfunction

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                          input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      case (e.port)
        PORT_CORE: check_eq("core_rd", bus.core_read_data, e.exp);
        PORT_W:    check_eq("weight_rd", bus.weight_read_data, e.exp);
        default:   check_eq("const_rd", bus.const_read_data, e.exp);
      endcase
    end
  endtask

  task automatic rd_core(input int unsigned a, input logic [DATA_W-1:0] exp);
    bus.core_read_addr = ADDR_W'(a);
    sb_q.push_back('{port: PORT_CORE, exp: exp});
  endtask

  task automatic rd_w(input int unsigned a, input logic [DATA_W-1:0] exp);
    bus.weight_read_addr = ADDR_W'(a);
    sb_q.push_back('{port: PORT_W, exp: exp});
  endtask

  task automatic rd_c(input int unsigned a, input logic [DATA_W-1:0] exp);
    bus.const_read_addr = ADDR_W'(a);
    sb_q.push_back('{port: PORT_C, exp: exp});
  endtask

  task automatic set_dma(input logic [1:0] tgt, input int unsigned a,
                         input logic [DATA_W-1:0] d);
    bus.dma_write_en = 1'b1;
    bus.dma_target   = tgt;
    bus.dma_addr     = ADDR_W'(a);
    bus.dma_wdata    = d;
  endtask

  task automatic dma_wr(input logic [1:0] tgt, input int unsigned a,
                        input logic [DATA_W-1:0] d);
    set_dma(tgt, a, d);
    tick();
    bus.dma_write_en = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] v_a5, v_11, v_22, v_33, v_44, v_ff;
    v_a5 = {32{8'hA5}};
    v_11 = {32{8'h11}};
    v_22 = {32{8'h22}};
    v_33 = {32{8'h33}};
    v_44 = {32{8'h44}};
    v_ff = {32{8'hFF}};
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    bus.bank_sel         = 1'b0;
    bus.core_read_addr   = '0;
    bus.core_write_en    = 1'b0;
    bus.core_write_addr  = '0;
    bus.core_write_data  = '0;
    bus.weight_read_addr = '0;
    bus.const_read_addr  = '0;
    bus.dma_write_en     = 1'b0;
    bus.dma_target       = '0;
    bus.dma_addr         = '0;
    bus.dma_wdata        = '0;

    tick();
    check_eq("reset_core", bus.core_read_data, '0);
    check_eq("reset_weight", bus.weight_read_data, '0);
    check_eq("reset_const", bus.const_read_data, '0);
    reset = 1'b1;
    tick();

    // Preload bank A and read it back through the core port.
    for (int k = 0; k < 8000; k++) dma_wr(DMA_RAM_A, k, pat(SEED_A, k));
    bus.bank_sel = 1'b0;
    for (int k = 0; k < 8000; k++) begin
      rd_core(k, pat(SEED_A, k));
      tick();
    end

    // Weight preload must not disturb const RAM or either activation bank.
    for (int i = 0; i < 512; i++) dma_wr(DMA_RAM_B, 2432 + i, pat(SEED_B, 2432 + i));
    for (int i = 0; i < 512; i++) dma_wr(DMA_CONST, 2432 + i, pat(SEED_C, 2432 + i));
    for (int i = 0; i < 512; i++) dma_wr(DMA_WEIGHT, W_BASE_OUTPROJ + i, pat(SEED_W, i));
    bus.bank_sel = 1'b0;
    for (int i = 0; i < 512; i++) begin
      rd_core(2432 + i, pat(SEED_A, 2432 + i));
      rd_w(W_BASE_OUTPROJ + i, pat(SEED_W, i));
      rd_c(2432 + i, pat(SEED_C, 2432 + i));
      tick();
    end
    bus.bank_sel = 1'b1;
    for (int i = 0; i < 512; i++) begin
      rd_core(2432 + i, pat(SEED_B, 2432 + i));
      tick();
    end

    // Core writes land in the bank opposite the read bank.
    dma_wr(DMA_RAM_A, 20000, pat(SEED_A, 20000));
    dma_wr(DMA_RAM_B, 20001, pat(SEED_B, 20001));
    bus.bank_sel        = 1'b0;
    bus.core_write_en   = 1'b1;
    bus.core_write_addr = ADDR_W'(20000);
    bus.core_write_data = v_a5;
    tick();
    bus.bank_sel        = 1'b1;
    bus.core_write_addr = ADDR_W'(20001);
    tick();
    bus.core_write_en   = 1'b0;
    check_eq("core_wr_b", dut.ram_b.ram[20000], v_a5);
    check_eq("core_wr_a_untouched", dut.ram_a.ram[20000], pat(SEED_A, 20000));
    check_eq("core_wr_a", dut.ram_a.ram[20001], v_a5);
    check_eq("core_wr_b_untouched", dut.ram_b.ram[20001], pat(SEED_B, 20001));

    // DMA and core hitting bank B together: DMA wins.
    bus.bank_sel        = 1'b0;
    bus.core_write_en   = 1'b1;
    bus.core_write_addr = ADDR_W'(5);
    bus.core_write_data = v_22;
    dma_wr(DMA_RAM_B, 5, v_11);
    bus.core_write_en   = 1'b0;
    check_eq("collision_peek", dut.ram_b.ram[5], v_11);
    bus.bank_sel = 1'b1;
    rd_core(5, v_11);
    tick();

    // Read-during-write returns the old word.
    bus.bank_sel = 1'b0;
    set_dma(DMA_RAM_A, 100, v_33);
    rd_core(100, pat(SEED_A, 100));
    tick();
    set_dma(DMA_RAM_A, 100, v_44);
    rd_core(100, v_33);
    tick();
    bus.dma_write_en = 1'b0;
    rd_core(100, v_44);
    tick();

    // Depth boundary on the reduced-depth const RAM: no wrap-around.
    dma_wr(DMA_CONST, 0, pat(SEED_C, 0));
    dma_wr(DMA_CONST, 16383, pat(SEED_C, 16383));
    dma_wr(DMA_CONST, 16384, v_ff);
    rd_c(16384, '0);
    tick();
    rd_c(16383, pat(SEED_C, 16383));
    tick();
    rd_c(0, pat(SEED_C, 0));
    tick();

    // Reset mid-stream clears outputs at once and leaves arrays intact.
    bus.bank_sel = 1'b0;
    rd_core(7, pat(SEED_A, 7));
    rd_w(W_BASE_OUTPROJ + 1, pat(SEED_W, 1));
    rd_c(2433, pat(SEED_C, 2433));
    tick();
    #2;
    reset = 1'b0;
    #1;
    check_eq("midrst_core", bus.core_read_data, '0);
    check_eq("midrst_weight", bus.weight_read_data, '0);
    check_eq("midrst_const", bus.const_read_data, '0);
    set_dma(DMA_RAM_A, 7, v_ff);
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.dma_write_en = 1'b0;
    reset = 1'b1;
    rd_core(7, pat(SEED_A, 7));
    rd_w(W_BASE_OUTPROJ + 1, pat(SEED_W, 1));
    rd_c(2433, pat(SEED_C, 2433));
    tick();
    check_eq("postrst_peek_b", dut.ram_b.ram[20000], v_a5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
